// File: rtl/fpadd_arbiter.sv
// Round-robin sharing of one combinational fpadd among NREQ requesters; 2-cycle grant-to-response latency.
// Backpressure: a stalled response holds RSP, then EX, then drops req_ready; nothing is dropped or reordered.
module fpadd_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [64*NREQ-1:0]  req_op1,
   input  logic [64*NREQ-1:0]  req_op2,
   input  logic [3*NREQ-1:0]   req_rm,
   input  logic [3*NREQ-1:0]   req_op_type,
   input  logic [2*NREQ-1:0]   req_p,
   input  logic                cfg_ov_en,
   input  logic                cfg_un_en,
   output logic [63:0]         fpu_op1,
   output logic [63:0]         fpu_op2,
   output logic [2:0]          fpu_rm,
   output logic [2:0]          fpu_op_type,
   output logic [1:0]          fpu_p,
   output logic                fpu_ov_en,
   output logic                fpu_un_en,
   input  logic [63:0]         fpu_result,
   input  logic [4:0]          fpu_flags,
   input  logic                fpu_denorm,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [63:0]         rsp_result,
   output logic [4:0]          rsp_flags,
   output logic                rsp_denorm,
   output logic                busy
);

   localparam int IDW = $clog2(NREQ);

   logic            ex_vld_q, ex_vld_d;
   logic [IDW-1:0]  ex_id_q, ex_id_d;
   logic [63:0]     ex_op1_q, ex_op1_d;
   logic [63:0]     ex_op2_q, ex_op2_d;
   logic [2:0]      ex_rm_q, ex_rm_d;
   logic [2:0]      ex_op_type_q, ex_op_type_d;
   logic [1:0]      ex_p_q, ex_p_d;

   logic            rsp_vld_q, rsp_vld_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [63:0]     rsp_result_q, rsp_result_d;
   logic [4:0]      rsp_flags_q, rsp_flags_d;
   logic            rsp_denorm_q, rsp_denorm_d;

   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

   logic            rsp_fire, rsp_free, ex_adv, ex_free;
   logic            gnt_vld;
   logic [IDW-1:0]  gnt_id;
   logic [IDW:0]    idx;

   assign rsp_fire = rsp_vld_q & rsp_ready[rsp_id_q];
   assign rsp_free = ~rsp_vld_q | rsp_fire;
   assign ex_adv   = ex_vld_q & rsp_free;
   assign ex_free  = ~ex_vld_q | ex_adv;

   // Grant is masked by reset so req_ready reads zero while reset_n is held low.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      if (ex_free && reset_n) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!gnt_vld && req_valid[idx]) begin
               gnt_vld = 1'b1;
               gnt_id  = idx[IDW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = gnt_vld && (gnt_id == IDW'(i));
         rsp_valid[i] = rsp_vld_q && (rsp_id_q == IDW'(i));
      end
   end

   always_comb begin
      ex_vld_d     = ex_vld_q;
      ex_id_d      = ex_id_q;
      ex_op1_d     = ex_op1_q;
      ex_op2_d     = ex_op2_q;
      ex_rm_d      = ex_rm_q;
      ex_op_type_d = ex_op_type_q;
      ex_p_d       = ex_p_q;
      rr_ptr_d     = rr_ptr_q;
      if (gnt_vld) begin
         ex_vld_d     = 1'b1;
         ex_id_d      = gnt_id;
         ex_op1_d     = req_op1[int'(gnt_id)*64 +: 64];
         ex_op2_d     = req_op2[int'(gnt_id)*64 +: 64];
         ex_rm_d      = req_rm[int'(gnt_id)*3 +: 3];
         ex_op_type_d = req_op_type[int'(gnt_id)*3 +: 3];
         ex_p_d       = req_p[int'(gnt_id)*2 +: 2];
         rr_ptr_d     = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      end else if (ex_adv) begin
         ex_vld_d = 1'b0;
      end
   end

   // A fire and an advance in the same cycle reload RSP directly, keeping full throughput.
   always_comb begin
      rsp_vld_d    = rsp_vld_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_denorm_d = rsp_denorm_q;
      if (ex_adv) begin
         rsp_vld_d    = 1'b1;
         rsp_id_d     = ex_id_q;
         rsp_result_d = fpu_result;
         rsp_flags_d  = fpu_flags;
         rsp_denorm_d = fpu_denorm;
      end else if (rsp_fire) begin
         rsp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_vld_q     <= 1'b0;
         ex_id_q      <= '0;
         ex_op1_q     <= '0;
         ex_op2_q     <= '0;
         ex_rm_q      <= '0;
         ex_op_type_q <= '0;
         ex_p_q       <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_denorm_q <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         ex_vld_q     <= ex_vld_d;
         ex_id_q      <= ex_id_d;
         ex_op1_q     <= ex_op1_d;
         ex_op2_q     <= ex_op2_d;
         ex_rm_q      <= ex_rm_d;
         ex_op_type_q <= ex_op_type_d;
         ex_p_q       <= ex_p_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_denorm_q <= rsp_denorm_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign fpu_op1     = ex_op1_q;
   assign fpu_op2     = ex_op2_q;
   assign fpu_rm      = ex_rm_q;
   assign fpu_op_type = ex_op_type_q;
   assign fpu_p       = ex_p_q;
   assign fpu_ov_en   = cfg_ov_en;
   assign fpu_un_en   = cfg_un_en;
   assign rsp_result  = rsp_result_q;
   assign rsp_flags   = rsp_flags_q;
   assign rsp_denorm  = rsp_denorm_q;
   assign busy        = ex_vld_q | rsp_vld_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a stand-in fpadd that knows two exact
// IEEE cases and otherwise returns a payload signature so routing can be traced.
module tb_fpadd_arbiter;

   localparam int NREQ = 4;

   logic               clk;
   logic               reset_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [64*NREQ-1:0] req_op1;
   logic [64*NREQ-1:0] req_op2;
   logic [3*NREQ-1:0]  req_rm;
   logic [3*NREQ-1:0]  req_op_type;
   logic [2*NREQ-1:0]  req_p;
   logic               cfg_ov_en;
   logic               cfg_un_en;
   logic [63:0]        fpu_op1, fpu_op2;
   logic [2:0]         fpu_rm, fpu_op_type;
   logic [1:0]         fpu_p;
   logic               fpu_ov_en, fpu_un_en;
   logic [63:0]        fpu_result;
   logic [4:0]         fpu_flags;
   logic               fpu_denorm;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [63:0]        rsp_result;
   logic [4:0]         rsp_flags;
   logic               rsp_denorm;
   logic               busy;

   int checks   = 0;
   int failures = 0;

   logic [63:0] d_op1 [NREQ];
   logic [63:0] d_op2 [NREQ];
   logic [2:0]  d_rm  [NREQ];
   logic [2:0]  d_ot  [NREQ];
   logic [1:0]  d_p   [NREQ];

   fpadd_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_rm(req_rm),
      .req_op_type(req_op_type), .req_p(req_p),
      .cfg_ov_en(cfg_ov_en), .cfg_un_en(cfg_un_en),
      .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_rm(fpu_rm),
      .fpu_op_type(fpu_op_type), .fpu_p(fpu_p),
      .fpu_ov_en(fpu_ov_en), .fpu_un_en(fpu_un_en),
      .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_denorm(fpu_denorm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_denorm(rsp_denorm),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in fpadd: 1.0+2.0=3.0 and x-x=+0 exactly, otherwise a traceable signature.
   always_comb begin
      fpu_result = fpu_op1 ^ fpu_op2 ^ 64'(fpu_op_type);
      fpu_flags  = {fpu_rm, fpu_p};
      fpu_denorm = fpu_op_type[0] ^ fpu_p[0];
      if (fpu_op_type == 3'b000 && fpu_op1 == 64'h3FF0000000000000 &&
          fpu_op2 == 64'h4000000000000000) begin
         fpu_result = 64'h4008000000000000;
         fpu_flags  = 5'b00000;
         fpu_denorm = 1'b0;
      end else if (fpu_op_type == 3'b001 && fpu_op1 == fpu_op2) begin
         fpu_result = 64'h0;
         fpu_flags  = 5'b00000;
         fpu_denorm = 1'b0;
      end
   end

   function automatic logic [63:0] exp_res(int i);
      return d_op1[i] ^ d_op2[i] ^ 64'(d_ot[i]);
   endfunction

   function automatic logic [4:0] exp_flags(int i);
      return {d_rm[i], d_p[i]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_defaults();
      for (int i = 0; i < NREQ; i++) begin
         d_op1[i] = 64'h0101010100000000 * 64'(i + 1);
         d_op2[i] = 64'h0000000011110000 * 64'(i + 1);
         d_rm[i]  = 3'(i);
         d_ot[i]  = 3'b000;
         d_p[i]   = 2'(3 - i);
      end
   endtask

   task automatic apply_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_op1[64*i +: 64]   = d_op1[i];
         req_op2[64*i +: 64]   = d_op2[i];
         req_rm[3*i +: 3]      = d_rm[i];
         req_op_type[3*i +: 3] = d_ot[i];
         req_p[2*i +: 2]       = d_p[i];
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 4'b0000;
      cfg_ov_en = 1'b1;
      cfg_un_en = 1'b0;
      init_defaults();
      apply_ops();
      #1;
      chk("reset_req_ready", 64'(req_ready), 64'h0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_fpu_op1", fpu_op1, 64'h0);
      chk("reset_rsp_result", rsp_result, 64'h0);
      chk("reset_rsp_flags", 64'(rsp_flags), 64'h0);
      chk("cfg_ov_en_pass", 64'(fpu_ov_en), 64'h1);
      chk("cfg_un_en_pass", 64'(fpu_un_en), 64'h0);
      req_valid = 4'b0000;
      tick();
      tick();
      reset_n = 1'b1;

      // Test 1: requester 0 adds 1.0 + 2.0
      d_op1[0] = 64'h3FF0000000000000;
      d_op2[0] = 64'h4000000000000000;
      d_rm[0]  = 3'b000;
      d_ot[0]  = 3'b000;
      apply_ops();
      req_valid = 4'b0001;
      #1;
      chk("t1_req_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("t1_fpu_op1", fpu_op1, 64'h3FF0000000000000);
      chk("t1_fpu_op2", fpu_op2, 64'h4000000000000000);
      chk("t1_rsp_not_yet", 64'(rsp_valid), 64'h0);
      chk("t1_busy", 64'(busy), 64'h1);
      tick();
      chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("t1_rsp_result", rsp_result, 64'h4008000000000000);
      chk("t1_rsp_flags", 64'(rsp_flags), 64'h0);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = 4'b0000;
      #1;
      chk("t1_rsp_drained", 64'(rsp_valid), 64'h0);
      chk("t1_idle", 64'(busy), 64'h0);

      // Test 2: requester 2 subtracts equal operands with RZ
      d_op1[2] = 64'h3FF0000000000000;
      d_op2[2] = 64'h3FF0000000000000;
      d_rm[2]  = 3'b001;
      d_ot[2]  = 3'b001;
      apply_ops();
      req_valid = 4'b0100;
      #1;
      chk("t2_req_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("t2_ready_one_cycle", 64'(req_ready), 64'h0);
      chk("t2_fpu_rm", 64'(fpu_rm), 64'h1);
      chk("t2_fpu_op_type", 64'(fpu_op_type), 64'h1);
      tick();
      chk("t2_rsp_valid", 64'(rsp_valid), 64'h4);
      chk("t2_rsp_result", rsp_result, 64'h0);
      rsp_ready = 4'b0100;
      tick();
      rsp_ready = 4'b0000;
      #1;
      chk("t2_rsp_drained", 64'(rsp_valid), 64'h0);

      // Reset to bring the round-robin pointer back to requester 0
      reset_n = 1'b0;
      init_defaults();
      apply_ops();
      tick();
      reset_n = 1'b1;

      // Test 3: all requesters streaming with responses always accepted
      rsp_ready = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         req_valid = (c < 6) ? 4'b1111 : 4'b0000;
         #1;
         if (c < 6) chk($sformatf("t3_grant_c%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
         else       chk($sformatf("t3_no_grant_c%0d", c), 64'(req_ready), 64'h0);
         if (c >= 2) begin
            chk($sformatf("t3_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(4'b0001 << ((c - 2) % 4)));
            chk($sformatf("t3_rsp_result_c%0d", c), rsp_result, exp_res((c - 2) % 4));
            chk($sformatf("t3_rsp_flags_c%0d", c), 64'(rsp_flags), 64'(exp_flags((c - 2) % 4)));
         end else begin
            chk($sformatf("t3_rsp_empty_c%0d", c), 64'(rsp_valid), 64'h0);
         end
         tick();
      end
      #1;
      chk("t3_idle", 64'(busy), 64'h0);
      rsp_ready = 4'b0000;

      // Test 5: fill EX and RSP, then reset asynchronously mid-cycle
      req_valid = 4'b0001;
      #1;
      chk("t5_grant_a", 64'(req_ready), 64'h1);
      tick();
      #1;
      chk("t5_grant_b", 64'(req_ready), 64'h1);
      tick();
      #1;
      chk("t5_full_no_ready", 64'(req_ready), 64'h0);
      chk("t5_full_busy", 64'(busy), 64'h1);
      chk("t5_full_rsp", 64'(rsp_valid), 64'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_async_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("t5_async_busy", 64'(busy), 64'h0);
      chk("t5_async_fpu_op1", fpu_op1, 64'h0);
      chk("t5_async_rsp_result", rsp_result, 64'h0);
      req_valid = 4'b1010;
      #1;
      chk("t5_async_req_ready", 64'(req_ready), 64'h0);
      tick();
      reset_n = 1'b1;
      #1;

      // Test 4: requesters 1 and 3 with responses stalled
      chk("t4_first_grant_lowest", 64'(req_ready), 64'h2);
      tick();
      req_valid = 4'b1000;
      #1;
      chk("t4_second_grant", 64'(req_ready), 64'h8);
      tick();
      req_valid = 4'b0001;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("t4_stall_ready_c%0d", c), 64'(req_ready), 64'h0);
         chk($sformatf("t4_stall_rsp_c%0d", c), 64'(rsp_valid), 64'h2);
         tick();
      end

      // Test 6: ready only on non-matching requesters leaves the pipeline frozen
      rsp_ready = 4'b1101;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("t6_rsp_hold_c%0d", c), 64'(rsp_valid), 64'h2);
         chk($sformatf("t6_no_grant_c%0d", c), 64'(req_ready), 64'h0);
         chk($sformatf("t6_ex_hold_c%0d", c), fpu_op1, d_op1[3]);
         tick();
      end

      req_valid = 4'b0000;
      rsp_ready = 4'b0010;
      #1;
      chk("t4_rsp1_valid", 64'(rsp_valid), 64'h2);
      chk("t4_rsp1_result", rsp_result, exp_res(1));
      tick();
      chk("t4_rsp3_valid", 64'(rsp_valid), 64'h8);
      chk("t4_rsp3_result", rsp_result, exp_res(3));
      chk("t4_rsp3_denorm", 64'(rsp_denorm), 64'(d_ot[3][0] ^ d_p[3][0]));
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = 4'b0000;
      #1;
      chk("t4_drained", 64'(rsp_valid), 64'h0);
      chk("t4_idle", 64'(busy), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
